// File: rtl/vga_timing_pkg.sv
// Shared types and default 800x600@60 timing constants for the raster generator.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FP,
      PH_SYNC,
      PH_BP
   } phase_e;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 40;
   localparam int DEF_H_SYNC   = 128;
   localparam int DEF_H_BP     = 88;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;
   localparam int DEF_CNT_W    = 11;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with a phase FSM; sync/blank flags are registered
// from the next phase so they always line up with the count shown in the same cycle.
//
// state     | meaning
// PH_ACTIVE | visible region, blank low
// PH_FP     | front porch, blank high
// PH_SYNC   | sync pulse, sync and blank high
// PH_BP     | back porch, blank high
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             adv_i,
   output logic [CNT_W-1:0] count_o,
   output logic             sync_o,
   output logic             blnk_o,
   output logic             wrap_o
);

   localparam logic [CNT_W-1:0] C_FP   = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] C_SYNC = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] C_BP   = CNT_W'(ACTIVE + FP + SYNC);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TOTAL - 1);
   localparam bit               HAS_FP = (FP > 0);

   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sync_q, blnk_q;

   assign wrap_o = adv_i && (count_q == C_LAST);

   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      if (adv_i) begin
         count_d = wrap_o ? '0 : count_q + CNT_W'(1);
         // a zero-length back porch leaves SYNC straight to ACTIVE at the wrap
         case (phase_q)
            PH_ACTIVE: if (count_d == C_FP)   phase_d = HAS_FP ? PH_FP : PH_SYNC;
            PH_FP:     if (count_d == C_SYNC) phase_d = PH_SYNC;
            PH_SYNC: begin
               if (count_d == '0)        phase_d = PH_ACTIVE;
               else if (count_d == C_BP) phase_d = PH_BP;
            end
            PH_BP:     if (count_d == '0)     phase_d = PH_ACTIVE;
            default:                          phase_d = PH_ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         phase_q <= PH_ACTIVE;
         count_q <= '0;
         sync_q  <= 1'b0;
         blnk_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         count_q <= count_d;
         sync_q  <= (phase_d == PH_SYNC);
         blnk_q  <= (phase_d != PH_ACTIVE);
      end
   end

   assign count_o = count_q;
   assign sync_o  = sync_q;
   assign blnk_o  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: horizontal axis steps on en, vertical axis steps on line wrap.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             frame_start
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   logic h_wrap, v_wrap;
   logic frame_start_q;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .TOTAL(H_TOTAL), .CNT_W(CNT_W)
   ) u_h_axis (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .adv_i  (en),
      .count_o(hcount),
      .sync_o (hsync),
      .blnk_o (hblnk),
      .wrap_o (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .TOTAL(V_TOTAL), .CNT_W(CNT_W)
   ) u_v_axis (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .adv_i  (h_wrap),
      .count_o(vcount),
      .sync_o (vsync),
      .blnk_o (vblnk),
      .wrap_o (v_wrap)
   );

   // v_wrap already implies en and a line wrap, so it marks the last pixel of the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_start_q <= 1'b0;
      else        frame_start_q <= v_wrap;
   end

   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks of the default 800x600 raster plus reference-model checks of small configs.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en_a = 1'b0;
   logic en_s = 1'b0;

   always #5 clk = ~clk;

   logic [10:0] a_hc, a_vc;
   logic        a_hs, a_vs, a_hb, a_vb, a_fs;

   logic [3:0] s_hc [4];
   logic [3:0] s_vc [4];
   logic       s_hs [4];
   logic       s_vs [4];
   logic       s_hb [4];
   logic       s_vb [4];
   logic       s_fs [4];

   int n_vec = 0;
   int n_err = 0;

   // small configs: 0 = H 4/1/2/1 V 3/1/1/1, 1 = no porches, 2 = no front porch, 3 = no back porch
   int ha[4] = '{4, 4, 4, 4};
   int hf[4] = '{1, 0, 0, 1};
   int hs[4] = '{2, 2, 2, 2};
   int hb[4] = '{1, 0, 1, 0};
   int va[4] = '{3, 3, 3, 3};
   int vf[4] = '{1, 0, 0, 1};
   int vs[4] = '{1, 1, 1, 1};
   int vb[4] = '{1, 0, 1, 0};

   vga_timing_gen u_def (
      .clk(clk), .rst_n(rst_n), .en(en_a),
      .hcount(a_hc), .vcount(a_vc), .hsync(a_hs), .vsync(a_vs),
      .hblnk(a_hb), .vblnk(a_vb), .frame_start(a_fs)
   );

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_W(4)) u_s0 (
      .clk(clk), .rst_n(rst_n), .en(en_s),
      .hcount(s_hc[0]), .vcount(s_vc[0]), .hsync(s_hs[0]), .vsync(s_vs[0]),
      .hblnk(s_hb[0]), .vblnk(s_vb[0]), .frame_start(s_fs[0])
   );

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(0),
                    .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(0), .CNT_W(4)) u_s1 (
      .clk(clk), .rst_n(rst_n), .en(en_s),
      .hcount(s_hc[1]), .vcount(s_vc[1]), .hsync(s_hs[1]), .vsync(s_vs[1]),
      .hblnk(s_hb[1]), .vblnk(s_vb[1]), .frame_start(s_fs[1])
   );

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(1), .CNT_W(4)) u_s2 (
      .clk(clk), .rst_n(rst_n), .en(en_s),
      .hcount(s_hc[2]), .vcount(s_vc[2]), .hsync(s_hs[2]), .vsync(s_vs[2]),
      .hblnk(s_hb[2]), .vblnk(s_vb[2]), .frame_start(s_fs[2])
   );

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(0),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(0), .CNT_W(4)) u_s3 (
      .clk(clk), .rst_n(rst_n), .en(en_s),
      .hcount(s_hc[3]), .vcount(s_vc[3]), .hsync(s_hs[3]), .vsync(s_vs[3]),
      .hblnk(s_hb[3]), .vblnk(s_vb[3]), .frame_start(s_fs[3])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_def(input string tag, input int hc, input int vc, input int hsy,
                          input int vsy, input int hbl, input int vbl, input int fs);
      chk({tag, "_hcount"}, 32'(a_hc), hc);
      chk({tag, "_vcount"}, 32'(a_vc), vc);
      chk({tag, "_hsync"},  32'(a_hs), hsy);
      chk({tag, "_vsync"},  32'(a_vs), vsy);
      chk({tag, "_hblnk"},  32'(a_hb), hbl);
      chk({tag, "_vblnk"},  32'(a_vb), vbl);
      chk({tag, "_fstart"}, 32'(a_fs), fs);
   endtask

   int mh[4], mv[4], mfs[4];
   int ht, vt;
   int ecnt0, nfs0;

   initial begin
      // reset held with en high
      en_a = 1'b1;
      #23;
      chk_def("rst", 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_s%0d_hc", k), 32'(s_hc[k]), 0);

      @(negedge clk);
      rst_n = 1'b1;
      step(5);
      chk_def("lat5", 5, 0, 0, 0, 0, 0, 0);

      // one line of horizontal decode
      step(794);
      chk_def("h799", 799, 0, 0, 0, 0, 0, 0);
      step(1);
      chk_def("h800", 800, 0, 0, 0, 1, 0, 0);
      step(39);
      chk_def("h839", 839, 0, 0, 0, 1, 0, 0);

      // freeze at 839 for 10 cycles
      en_a = 1'b0;
      step(10);
      chk_def("frz", 839, 0, 0, 0, 1, 0, 0);
      en_a = 1'b1;
      step(1);
      chk_def("h840", 840, 0, 1, 0, 1, 0, 0);
      step(127);
      chk_def("h967", 967, 0, 1, 0, 1, 0, 0);
      step(1);
      chk_def("h968", 968, 0, 0, 0, 1, 0, 0);
      step(87);
      chk_def("h1055", 1055, 0, 0, 0, 1, 0, 0);
      step(1);
      chk_def("hwrap", 0, 1, 0, 0, 0, 0, 0);
      step(900);
      chk_def("h900l1", 900, 1, 1, 0, 1, 0, 0);
      en_a = 1'b0;

      // small configs against a counting model, with periodic enable drops
      for (int k = 0; k < 4; k++) begin
         mh[k] = 0;
         mv[k] = 0;
         mfs[k] = 0;
      end
      ecnt0 = 0;
      nfs0 = 0;
      for (int i = 0; i < 200; i++) begin
         en_s = ((i % 7) != 3);
         step(1);
         for (int k = 0; k < 4; k++) begin
            ht = ha[k] + hf[k] + hs[k] + hb[k];
            vt = va[k] + vf[k] + vs[k] + vb[k];
            mfs[k] = 0;
            if (en_s) begin
               mfs[k] = (mh[k] == ht - 1 && mv[k] == vt - 1) ? 1 : 0;
               if (mh[k] == ht - 1) begin
                  mh[k] = 0;
                  mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
               end else begin
                  mh[k] = mh[k] + 1;
               end
            end
            chk($sformatf("s%0d_hcount", k), 32'(s_hc[k]), mh[k]);
            chk($sformatf("s%0d_vcount", k), 32'(s_vc[k]), mv[k]);
            chk($sformatf("s%0d_hblnk", k), 32'(s_hb[k]), (mh[k] >= ha[k]) ? 1 : 0);
            chk($sformatf("s%0d_vblnk", k), 32'(s_vb[k]), (mv[k] >= va[k]) ? 1 : 0);
            chk($sformatf("s%0d_hsync", k), 32'(s_hs[k]),
                (mh[k] >= ha[k] + hf[k] && mh[k] < ha[k] + hf[k] + hs[k]) ? 1 : 0);
            chk($sformatf("s%0d_vsync", k), 32'(s_vs[k]),
                (mv[k] >= va[k] + vf[k] && mv[k] < va[k] + vf[k] + vs[k]) ? 1 : 0);
            chk($sformatf("s%0d_fstart", k), 32'(s_fs[k]), mfs[k]);
         end
         if (en_s) ecnt0++;
         if (s_fs[0]) begin
            chk("s0_frame_period", 32'(ecnt0), 48);
            ecnt0 = 0;
            nfs0++;
         end
      end
      chk("s0_frame_count", 32'(nfs0), 3);
      en_s = 1'b0;

      // default instance stayed frozen mid-line; now reset it asynchronously
      chk_def("frz2", 900, 1, 1, 0, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      chk_def("midrst", 0, 0, 0, 0, 0, 0, 0);
      chk("midrst_s0_vcount", 32'(s_vc[0]), 0);

      @(negedge clk);
      rst_n = 1'b1;
      en_a = 1'b1;
      en_s = 1'b1;
      step(1);
      chk_def("restart", 1, 0, 0, 0, 0, 0, 0);
      chk("restart_s0_hcount", 32'(s_hc[0]), 1);
      chk("restart_s0_fstart", 32'(s_fs[0]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
